// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and defaults for the FIFO burst read engine.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 5;
  localparam int FIFO_DEPTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry valid/ready output buffer. Head entry drives the stream;
// a push and a pop in the same cycle keep FIFO order and occupancy.
module fifo_skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid_i,
  input  logic [W-1:0] s_data_i,
  output logic         s_ready_o,
  output logic         m_valid_o,
  output logic [W-1:0] m_data_o,
  input  logic         m_ready_i,
  output logic [1:0]   occ_o
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   occ_q, occ_d;
  logic         push;
  logic         pop;

  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = e0_q;
  assign occ_o     = occ_q;
  // A full buffer can still take a word when the head leaves this cycle.
  assign s_ready_o = (occ_q != 2'd2) || m_ready_i;
  assign push      = s_valid_i && s_ready_o;
  assign pop       = m_valid_o && m_ready_i;

  // Next-state for the two entries and the occupancy count.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          e0_d  = s_data_i;
          occ_d = 2'd1;
        end
      end
      2'd1: begin
        case ({push, pop})
          2'b11: e0_d = s_data_i;
          2'b10: begin
            e1_d  = s_data_i;
            occ_d = 2'd2;
          end
          2'b01: occ_d = 2'd0;
          default: ;
        endcase
      end
      default: begin
        if (pop) begin
          e0_d = e1_q;
          if (push) begin
            e1_d = s_data_i;
          end else begin
            occ_d = 2'd1;
          end
        end
      end
    endcase
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst engine: drains a FIFO in fixed bursts, or in a partial
// burst after an idle timeout, onto a valid/ready stream with a last marker.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_fillcount,
  output logic              fifo_get,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  burst_len_q
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

  state_e              state_q, state_d;
  logic                fifo_get_q, fifo_get_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    burst_len_d;
  logic [TMR_W-1:0]    idle_tmr_q, idle_tmr_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    deliver_cnt_q, deliver_cnt_d;
  logic                rd_vld_q;
  logic                hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;

  logic                s_valid;
  logic [DATA_W-1:0]   s_data;
  logic                s_ready;
  logic [1:0]          occ;
  logic                pop;
  logic                last_word;
  logic [2:0]          committed;
  logic                room;

  assign fifo_get  = fifo_get_q;
  assign busy      = busy_q;
  assign pop       = m_valid && m_ready;
  assign last_word = (deliver_cnt_q == (burst_len_q - CNT_W'(1)));
  assign m_last    = m_valid && last_word;

  // Every word already promised storage: buffered, landing, returning this
  // cycle, or requested by the current strobe. Three slots exist (two in the
  // buffer plus the landing register), so a new read is issued only while the
  // promised total, net of this cycle's pop, stays below three. With the
  // stream accepting every cycle this still sustains one read per cycle.
  assign committed = 3'(occ) + 3'(hold_vld_q) + 3'(rd_vld_q) + 3'(fifo_get_q);
  assign room      = committed < (3'd3 + 3'(pop));

  fifo_skid_buf2 #(
    .W(DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .s_valid_i (s_valid),
    .s_data_i  (s_data),
    .s_ready_o (s_ready),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .m_ready_i (m_ready),
    .occ_o     (occ)
  );

  // Returning read data goes straight into the buffer; it parks in the
  // landing register only when the buffer is full and not draining.
  always_comb begin
    s_valid     = hold_vld_q || rd_vld_q;
    s_data      = hold_vld_q ? hold_data_q : fifo_data_out;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (hold_vld_q) begin
      if (s_ready) begin
        hold_vld_d  = rd_vld_q;
        hold_data_d = fifo_data_out;
      end
    end else if (rd_vld_q && !s_ready) begin
      hold_vld_d  = 1'b1;
      hold_data_d = fifo_data_out;
    end
  end

  // Burst FSM: start decision, idle timer, read issue and delivery counting.
  always_comb begin
    state_d       = state_q;
    burst_len_d   = burst_len_q;
    idle_tmr_d    = idle_tmr_q;
    issue_cnt_d   = issue_cnt_q;
    deliver_cnt_d = deliver_cnt_q;
    fifo_get_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_fillcount >= BURST_CNT) begin
          state_d     = DRAIN;
          burst_len_d = BURST_CNT;
          idle_tmr_d  = '0;
        end else if ((fifo_fillcount != '0) && (idle_tmr_q == TMR_LAST)) begin
          state_d     = DRAIN;
          burst_len_d = fifo_fillcount;
          idle_tmr_d  = '0;
        end else if (fifo_fillcount == '0) begin
          idle_tmr_d = '0;
        end else if (idle_tmr_q != TMR_LAST) begin
          idle_tmr_d = idle_tmr_q + TMR_W'(1);
        end
      end
      DRAIN: begin
        fifo_get_d = (issue_cnt_q < burst_len_q) && !fifo_empty && room;
        if (fifo_get_d) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
        if (pop) begin
          if (last_word) begin
            state_d       = IDLE;
            burst_len_d   = '0;
            issue_cnt_d   = '0;
            deliver_cnt_d = '0;
            idle_tmr_d    = '0;
          end else begin
            deliver_cnt_d = deliver_cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
    busy_d = (state_d == DRAIN);
  end

  // Control, counter and landing registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      fifo_get_q    <= 1'b0;
      busy_q        <= 1'b0;
      burst_len_q   <= '0;
      idle_tmr_q    <= '0;
      issue_cnt_q   <= '0;
      deliver_cnt_q <= '0;
      rd_vld_q      <= 1'b0;
      hold_vld_q    <= 1'b0;
      hold_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      fifo_get_q    <= fifo_get_d;
      busy_q        <= busy_d;
      burst_len_q   <= burst_len_d;
      idle_tmr_q    <= idle_tmr_d;
      issue_cnt_q   <= issue_cnt_d;
      deliver_cnt_q <= deliver_cnt_d;
      rd_vld_q      <= fifo_get_q;
      hold_vld_q    <= hold_vld_d;
      hold_data_q   <= hold_data_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, stream scoreboard, vector table
// and hand-written corner sequences.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] fifo_data_out = 8'h00;
  logic       fifo_empty;
  logic [4:0] fifo_fillcount;
  logic       fifo_get;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready = 1'b0;
  logic       busy;
  logic [4:0] burst_len_q;

  fifo_burst_reader #(
    .DATA_W(8), .CNT_W(5), .BURST_LEN(4), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_fillcount(fifo_fillcount),
    .fifo_get(fifo_get), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .busy(busy),
    .burst_len_q(burst_len_q)
  );

  always #5 clk = ~clk;

  // FIFO model: data valid the cycle after a get.
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       force_empty = 1'b0;
  assign fifo_fillcount = 5'(wr_ptr - rd_ptr);
  assign fifo_empty     = (wr_ptr == rd_ptr) || force_empty;
  always @(posedge clk) begin
    if (fifo_get) begin
      fifo_data_out <= mem[rd_ptr[7:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  typedef struct { logic [7:0] d; logic l; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endfunction

  // Stream monitor: drives m_ready, counts gets, scores accepted words.
  int         ready_mode = 0;
  int         pidx = 0;
  logic [5:0] pat = 6'b101001;
  int         gets = 0, lasts = 0, acc = 0, gap = 0, max_gap = 0;
  logic       prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (!reset) begin
      m_ready    = 1'b0;
      prev_stall = 1'b0;
      gap        = 0;
    end else begin
      case (ready_mode)
        1: begin m_ready = pat[pidx]; pidx = (pidx + 1) % 6; end
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      if (fifo_get) gets++;
      if (prev_stall) begin
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_data", int'(m_data), int'(prev_data));
        chk("stall_last", int'(m_last), int'(prev_last));
      end
      if (m_valid && m_ready) begin
        acc++;
        if (m_last) lasts++;
        if (exp_q.size() == 0) begin
          chk("extra_word", int'(m_data), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_data", int'(m_data), int'(e.d));
          chk("word_last", int'(m_last), int'(e.l));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (busy || fifo_fillcount < 5'd4) gap = 0;
      else begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = 8'(base + i);
      e.l = ((i % 4) == 3) || (i == n - 1);
      mem[wr_ptr[7:0]] = e.d;
      exp_q.push_back(e);
      wr_ptr++;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(exp_q.size() == 0 && !busy && wr_ptr == rd_ptr) && n < budget);
    if (n >= budget) chk({name, "_timeout"}, n, -1);
  endtask

  typedef struct { int nwords; int base; int rmode; int exp_gets; int exp_lasts; } vec_t;
  vec_t vecs[6];

  initial begin
    #400000;
    $display("FAIL watchdog: got=expired want=finish");
    $fatal(1);
  end

  initial begin
    int g0, l0, a0, ng, n;
    int eg[7], ev[7], ed[7], el[7], eb[7];
    vecs[0] = '{4,  'h20, 0, 4,  1};
    vecs[1] = '{12, 'h40, 0, 12, 3};
    vecs[2] = '{4,  'h60, 1, 4,  1};
    vecs[3] = '{6,  'h70, 0, 6,  2};
    vecs[4] = '{8,  'h80, 2, 8,  2};
    vecs[5] = '{1,  'h90, 1, 1,  1};

    // Reset state
    repeat (3) step();
    chk("rst_get", int'(fifo_get), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_last", int'(m_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_len", int'(burst_len_q), 0);
    reset = 1'b1;
    repeat (2) step();

    // Threshold burst: cycle-exact timing from the first get
    ready_mode = 0;
    load(4, 'h11);
    n = 0;
    do begin step(); n++; end while (!fifo_get && n < 30);
    chk("thr_first_get", int'(fifo_get), 1);
    eg = '{1, 1, 1, 1, 0, 0, 0};
    ev = '{0, 0, 1, 1, 1, 1, 0};
    ed = '{0, 0, 'h11, 'h12, 'h13, 'h14, 0};
    el = '{0, 0, 0, 0, 0, 1, 0};
    eb = '{1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("thr_get%0d", i), int'(fifo_get), eg[i]);
      chk($sformatf("thr_valid%0d", i), int'(m_valid), ev[i]);
      if (ev[i] != 0) chk($sformatf("thr_data%0d", i), int'(m_data), ed[i]);
      chk($sformatf("thr_last%0d", i), int'(m_last), el[i]);
      chk($sformatf("thr_busy%0d", i), int'(busy), eb[i]);
      step();
    end
    wait_idle(50, "thr");

    // Partial flush after the idle timeout
    repeat (3) step();
    load(2, 'hA0);
    ng = 0;
    for (int j = 1; j <= 15; j++) begin
      step();
      if (fifo_get) ng++;
      if (j == 14) chk("part_busy14", int'(busy), 0);
      if (j == 15) begin
        chk("part_busy15", int'(busy), 1);
        chk("part_len", int'(burst_len_q), 2);
      end
    end
    chk("part_no_get", ng, 0);
    wait_idle(50, "part");

    // Under-run: FIFO reports empty after two gets
    g0 = gets;
    load(4, 'h30);
    ng = 0;
    n  = 0;
    do begin step(); n++; if (fifo_get) ng++; end while (ng < 2 && n < 30);
    force_empty = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      chk($sformatf("under_noget%0d", j), int'(fifo_get), 0);
    end
    chk("under_len", int'(burst_len_q), 4);
    force_empty = 1'b0;
    wait_idle(60, "under");
    chk("under_gets", gets - g0, 4);

    // Vector table
    for (int v = 0; v < 6; v++) begin
      ready_mode = vecs[v].rmode;
      step();
      max_gap = 0;
      g0 = gets;
      l0 = lasts;
      load(vecs[v].nwords, vecs[v].base);
      wait_idle(400, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_gets", v), gets - g0, vecs[v].exp_gets);
      chk($sformatf("vec%0d_lasts", v), lasts - l0, vecs[v].exp_lasts);
      chk($sformatf("vec%0d_gap", v), int'(max_gap <= 1), 1);
    end

    // Reset in the middle of a burst
    ready_mode = 0;
    step();
    a0 = acc;
    load(8, 'h50);
    n = 0;
    do begin step(); n++; end while (acc < a0 + 2 && n < 40);
    chk("mid_two_words", acc - a0, 2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_get", int'(fifo_get), 0);
    chk("mid_valid", int'(m_valid), 0);
    chk("mid_data", int'(m_data), 0);
    chk("mid_last", int'(m_last), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_len", int'(burst_len_q), 0);
    exp_q.delete();
    repeat (2) step();
    chk("mid_hold_busy", int'(busy), 0);
    reset = 1'b1;
    n = wr_ptr - rd_ptr;
    chk("mid_remaining", n, 4);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = mem[8'(rd_ptr + i)];
      e.l = ((i % 4) == 3) || (i == n - 1);
      exp_q.push_back(e);
    end
    ng = 0;
    do begin step(); ng++; end while (!busy && ng < 20);
    chk("rearm_len", int'(burst_len_q), 4);
    wait_idle(60, "rearm");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
